// File: rtl/mux8way16_arbiter.sv
// Round-robin arbiter that shares one 16-bit Mux8Way16 datapath among eight requesters.
// Grants are registered and bounded to MAX_HOLD cycles while others wait; the selected word is registered.
module mux8way16_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  output logic [7:0]       gnt,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [HW-1:0]   hold_cnt;
  logic [WIDTH-1:0] words [8];

  logic       owner_req;
  logic       others;
  logic       hold_max;
  logic [2:0] win_idle;
  logic [2:0] win_next;

  assign words[0] = a;
  assign words[1] = b;
  assign words[2] = c;
  assign words[3] = d;
  assign words[4] = e;
  assign words[5] = f;
  assign words[6] = g;
  assign words[7] = h;

  // First set bit of r scanning start, start+1, ... with wrap from 7 to 0.
  function automatic logic [2:0] search(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    search = start;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) search = idx;
    end
  endfunction

  assign owner_req = req[sel];
  assign others    = |(req & ~(8'b1 << sel));
  assign hold_max  = (hold_cnt == HW'(MAX_HOLD));
  assign win_idle  = search(req, ptr);
  assign win_next  = search(req, sel + 3'd1);
  assign busy      = (state == GRANT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'd0;
      sel       <= 3'd0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state == GRANT) && owner_req;
      if ((state == GRANT) && owner_req) out <= words[sel];

      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 8'b1 << win_idle;
            sel      <= win_idle;
            hold_cnt <= HW'(1);
          end
        end
        GRANT: begin
          // Release or rotation: hand over directly to the next requester, no idle bubble.
          if (!owner_req || (hold_max && others)) begin
            ptr <= sel + 3'd1;
            if (|req) begin
              gnt      <= 8'b1 << win_next;
              sel      <= win_next;
              hold_cnt <= HW'(1);
            end else begin
              state    <= IDLE;
              gnt      <= 8'd0;
              hold_cnt <= '0;
            end
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux8way16_arbiter.sv
// Self-checking bench: an abstract round-robin model checked every cycle, plus directed literal checks.
module tb_mux8way16_arbiter;
  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       req = 8'd0;
  logic [WIDTH-1:0] din [8];
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mux8way16_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .a(din[0]), .b(din[1]), .c(din[2]), .d(din[3]),
    .e(din[4]), .f(din[5]), .g(din[6]), .h(din[7]),
    .gnt(gnt), .sel(sel), .out(out), .out_valid(out_valid), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), search start, cycles held.
  int               m_owner = -1;
  int               m_ptr = 0;
  int               m_hold = 0;
  int               m_sel = 0;
  logic [WIDTH-1:0] m_out = '0;
  logic             m_valid = 1'b0;
  bit               model_ok = 1'b0;

  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int o, p, hc, s;
    logic [WIDTH-1:0] ov;
    logic v;
    o = m_owner; p = m_ptr; hc = m_hold; s = m_sel; ov = m_out;
    if (!reset_n) begin
      o = -1; p = 0; hc = 0; s = 0; ov = '0; v = 1'b0;
    end else begin
      v = (o >= 0) && req[o];
      if (v) ov = din[o];
      if (o < 0) begin
        if (req != 8'd0) begin o = pick(req, p); hc = 1; end
      end else if (!req[o] || (hc == MAX_HOLD && req != (8'd1 << o))) begin
        p = (o + 1) % 8;
        o = pick(req, p);
        hc = (o >= 0) ? 1 : 0;
      end else if (hc < MAX_HOLD) begin
        hc = hc + 1;
      end
      if (o >= 0) s = o;
    end
    m_owner  <= o;
    m_ptr    <= p;
    m_hold   <= hc;
    m_sel    <= s;
    m_out    <= ov;
    m_valid  <= v;
    model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      check("cyc_sel", 32'(sel), 32'(m_sel));
      check("cyc_out", 32'(out), 32'(m_out));
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 8'd0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    din[0] = 16'hA0A0; din[1] = 16'hB1B1; din[2] = 16'h3456; din[3] = 16'hD3D3;
    din[4] = 16'hE4E4; din[5] = 16'hF5F5; din[6] = 16'h0606; din[7] = 16'h7777;
    repeat (2) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;

    // Single request
    req = 8'b0000_0100;
    @(negedge clk);
    $display("t1 single: gnt=%b sel=%0d busy=%0d", gnt, sel, busy);
    check("t1_gnt", 32'(gnt), 32'h04);
    check("t1_sel", 32'(sel), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_out", 32'(out), 32'h3456);
    check("t1_out_valid", 32'(out_valid), 32'd1);

    // Full contention: each owner in turn for exactly MAX_HOLD cycles
    pulse_reset();
    req = 8'hFF;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      check("t2_rotate_gnt", 32'(gnt), 32'd1 << (((k - 1) / 4) % 8));
    end
    $display("t2 contention: final gnt=%b", gnt);

    // Lone holder with changing data word
    pulse_reset();
    req = 8'b0010_0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_lone_gnt", 32'(gnt), 32'h20);
      din[5] = 16'(16'h5000 + k);
    end
    req = 8'd0;
    @(negedge clk);
    check("t3_drop_gnt", 32'(gnt), 32'd0);
    check("t3_drop_busy", 32'(busy), 32'd0);
    $display("t3 lone holder: out=%h", out);

    // Release handoff without bubble
    pulse_reset();
    req = 8'b0000_0001;
    @(negedge clk);
    req = 8'b1000_0011;
    @(negedge clk);
    check("t4_owner0", 32'(gnt), 32'h01);
    req = 8'b1000_0010;
    @(negedge clk);
    check("t4_handoff1", 32'(gnt), 32'h02);
    req = 8'b1000_0000;
    @(negedge clk);
    check("t4_handoff7", 32'(gnt), 32'h80);
    $display("t4 handoff: gnt=%b", gnt);

    // Reset mid-grant
    pulse_reset();
    req = 8'b0000_1000;
    repeat (2) @(negedge clk);
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_sel", 32'(sel), 32'd0);
    check("t5_out", 32'(out), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    req = 8'hFF;
    @(negedge clk);
    check("t5_ptr0_gnt", 32'(gnt), 32'h01);
    $display("t5 reset mid-grant: gnt=%b", gnt);

    // Wrap with same-cycle swap 7 -> 0
    pulse_reset();
    req = 8'b1000_0000;
    repeat (2) @(negedge clk);
    req = 8'b0000_0001;
    @(negedge clk);
    check("t6_gnt", 32'(gnt), 32'h01);
    check("t6_gap_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 32'd1);
    check("t6_out", 32'(out), 32'hA0A0);
    $display("t6 wrap swap: gnt=%b out=%h", gnt, out);

    // Non-owner churn while an owner holds
    req = 8'b0001_0001;
    @(negedge clk);
    req = 8'b0100_0001;
    @(negedge clk);
    req = 8'b0000_0001;
    repeat (3) @(negedge clk);
    req = 8'd0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
